segasys1_sndcmd: RTL and testbench

Sound-command mailbox between the System 1 main CPU and the sound CPU. It captures each command byte the main CPU issues on its sound-request port (SNDRQ pulse with SNDNO) and buffers it. It raises an edge-correct NMI request to the sound CPU and returns the byte when the sound CPU reads its command-latch window. It sits directly downstream of the main-CPU block and upstream of the sound-CPU data selector.

---
 rtl/segasys1_pkg.sv | 13 +
 rtl/segasys1_sndfifo.sv | 47 ++++
 rtl/segasys1_sndcmd.sv | 110 +++++++++++
 tb/tb_segasys1_sndcmd.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_pkg.sv
// segasys1_pkg: shared constants and types for the System 1 sound-command path
package segasys1_pkg;

    localparam logic [3:0] SND_WIN     = 4'hE;
    localparam int         NMI_GAP_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        GAP
    } nmi_state_t;

endpackage

// File: rtl/segasys1_sndfifo.sv
// segasys1_sndfifo: command FIFO with occupancy, sticky overflow and a registered head byte
module segasys1_sndfifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, nx_rd;
    logic          full, pop_v, wr_en;

    assign full  = level == (AW+1)'(DEPTH);
    assign pop_v = pop && level != '0;
    assign wr_en = push && (!full || pop_v);
    assign nx_rd = pop_v ? rd_ptr + 1'b1 : rd_ptr;

    // storage, pointers and occupancy; dout tracks the byte that will sit at rd_ptr after this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            dout   <= 8'h00;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= nx_rd;
            level  <= level + (AW+1)'(wr_en) - (AW+1)'(pop_v);
            if (push && !wr_en) ovf <= 1'b1;
            dout   <= (wr_en && wr_ptr == nx_rd) ? din : mem[nx_rd];
        end
    end

endmodule

// File: rtl/segasys1_sndcmd.sv
// segasys1_sndcmd: main-to-sound CPU command mailbox with paced NMI; SNDCMD_FIFO_EN selects a DEPTH-entry FIFO instead of a one-byte latch
module segasys1_sndcmd
    import segasys1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NMI_GAP = NMI_GAP_DEF
) (
    input  logic        CLK48M,
    input  logic        RESET,
    input  logic        SNDRQ,
    input  logic [7:0]  SNDNO,
    input  logic [15:0] SCPUAD,
    input  logic        SCPURD,
    output logic        SNDCS,
    output logic [7:0]  SNDDO,
    output logic        SNMI,
    output logic        SNDOVF,
`ifdef SNDCMD_FIFO_EN
    output logic [$clog2(DEPTH):0] LEVEL
`else
    output logic [0:0]  LEVEL
`endif
);

    localparam int             CW       = $clog2(NMI_GAP + 1);
    localparam logic [CW-1:0]  GAP_LOAD = CW'(NMI_GAP - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("segasys1_sndcmd: DEPTH must be a power of two >= 2");
    end

    logic          rq_q, cs_q, push, pop;
    logic [CW-1:0] gap_cnt;
    nmi_state_t    state;

    assign SNDCS = SCPURD && SCPUAD >= {SND_WIN, 12'h000} && SCPUAD <= {SND_WIN, 12'hFFF};
    assign push  = SNDRQ && !rq_q;
    assign pop   = cs_q && !SNDCS;

    // previous-cycle request and chip-select for edge detection
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            rq_q <= 1'b0;
            cs_q <= 1'b0;
        end else begin
            rq_q <= SNDRQ;
            cs_q <= SNDCS;
        end
    end

`ifdef SNDCMD_FIFO_EN
    segasys1_sndfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK48M),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (SNDNO),
        .dout  (SNDDO),
        .level (LEVEL),
        .ovf   (SNDOVF)
    );
`else
    assign SNDOVF = 1'b0;

    // single-byte latch: newest command always wins, a pop only clears the pending flag
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            SNDDO <= 8'h00;
            LEVEL <= 1'b0;
        end else if (push) begin
            SNDDO <= SNDNO;
            LEVEL <= 1'b1;
        end else if (pop) begin
            LEVEL <= 1'b0;
        end
    end
`endif

    // NMI pacing: assert while a command waits, then hold low NMI_GAP cycles after each read
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            state   <= IDLE;
            SNMI    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (LEVEL != '0) begin
                    state <= ASSERT;
                    SNMI  <= 1'b1;
                end
                ASSERT: if (pop) begin
                    state   <= GAP;
                    SNMI    <= 1'b0;
                    gap_cnt <= GAP_LOAD;
                end
                GAP: if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end else begin
                    state <= LEVEL != '0 ? ASSERT : IDLE;
                    SNMI  <= LEVEL != '0;
                end
                default: begin
                    state <= IDLE;
                    SNMI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segasys1_sndcmd.sv
// tb_segasys1_sndcmd: randomized self-checking bench against a queue-based mailbox model
module tb_segasys1_sndcmd;

`ifdef SNDCMD_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    localparam int LW  = CAP == 1 ? 1 : $clog2(CAP) + 1;
    localparam int GAP = 32;

    logic          clk = 1'b0;
    logic          rst, rq, rd, cs, nmi, ovf_o;
    logic [7:0]    no, dout;
    logic [15:0]   ad;
    logic [LW-1:0] level;

    int vec  = 0;
    int errs = 0;

    byte unsigned q[$];
    bit           ovf;

    segasys1_sndcmd #(.DEPTH(4), .NMI_GAP(GAP)) dut (
        .CLK48M (clk),
        .RESET  (rst),
        .SNDRQ  (rq),
        .SNDNO  (no),
        .SCPUAD (ad),
        .SCPURD (rd),
        .SNDCS  (cs),
        .SNDDO  (dout),
        .SNMI   (nmi),
        .SNDOVF (ovf_o),
        .LEVEL  (level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // model: a bounded queue; a one-entry mailbox replaces its byte, a deeper one drops and flags
    function automatic void model_push(input byte unsigned b);
        if (q.size() < CAP) q.push_back(b);
        else if (CAP == 1) q[0] = b;
        else ovf = 1'b1;
    endfunction

    function automatic void model_pop();
        if (q.size() > 0) void'(q.pop_front());
    endfunction

    task automatic do_reset;
        rst = 1'b1; rq = 1'b0; rd = 1'b0; ad = 16'h0000; no = 8'h00;
        tick;
        rst = 1'b0;
        q.delete();
        ovf = 1'b0;
        tick;
    endtask

    task automatic push(input logic [7:0] b, input int len);
        no = b;
        rq = 1'b1;
        model_push(b);
        repeat (len) tick;
        rq = 1'b0;
        tick;
    endtask

    task automatic read(input int len, output logic [7:0] got);
        ad = {4'hE, 12'($urandom)};
        rd = 1'b1;
        repeat (len) tick;
        got = dout;
        rd = 1'b0;
        tick;
        model_pop();
    endtask

    task automatic test_reset;
        rst = 1'b1; rq = 1'b0; rd = 1'b0; ad = 16'h0000; no = 8'h00;
        repeat (2) tick;
        vec++; if (dout !== 8'h00) begin errs++; $display("FAIL reset_snddo: got %h want 00", dout); end
        vec++; if (nmi !== 1'b0) begin errs++; $display("FAIL reset_snmi: got %b want 0", nmi); end
        vec++; if (level !== '0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
        vec++; if (ovf_o !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        rst = 1'b0;
        q.delete();
        ovf = 1'b0;
        tick;
    endtask

    task automatic test_single;
        bit hi = 1'b0;
        no = 8'h5A; rq = 1'b1; model_push(8'h5A);
        tick;
        vec++; if (level !== LW'(1)) begin errs++; $display("FAIL single_level: got %0d want 1", level); end
        vec++; if (dout !== 8'h5A) begin errs++; $display("FAIL single_snddo: got %h want 5a", dout); end
        vec++; if (nmi !== 1'b0) begin errs++; $display("FAIL single_snmi_early: got %b want 0", nmi); end
        tick;
        vec++; if (nmi !== 1'b1) begin errs++; $display("FAIL single_snmi_rise: got %b want 1", nmi); end
        repeat (14) tick;
        rq = 1'b0;
        tick;
        ad = 16'hE000; rd = 1'b1;
        #1;
        vec++; if (cs !== 1'b1) begin errs++; $display("FAIL single_sndcs_on: got %b want 1", cs); end
        for (int i = 0; i < 12; i++) begin
            tick;
            vec++; if (dout !== 8'h5A) begin errs++; $display("FAIL single_hold[%0d]: got %h want 5a", i, dout); end
        end
        rd = 1'b0;
        #1;
        vec++; if (cs !== 1'b0) begin errs++; $display("FAIL single_sndcs_off: got %b want 0", cs); end
        tick;
        model_pop();
        vec++; if (level !== '0) begin errs++; $display("FAIL single_level_pop: got %0d want 0", level); end
        vec++; if (nmi !== 1'b0) begin errs++; $display("FAIL single_snmi_pop: got %b want 0", nmi); end
        for (int i = 0; i < 40; i++) begin
            tick;
            hi |= nmi !== 1'b0;
        end
        vec++; if (hi) begin errs++; $display("FAIL single_idle: got snmi high want low"); end
    endtask

    task automatic test_sndcs;
        logic exp;
        for (int i = 0; i < 16; i++) begin
            ad = 16'($urandom);
            if (i % 3 == 0) ad[15:12] = 4'hE;
            rd = 1'($urandom);
            exp = (ad >> 12) == 16'hE && rd;
            #1;
            vec++; if (cs !== exp) begin errs++; $display("FAIL sndcs[%h,%b]: got %b want %b", ad, rd, cs, exp); end
            tick;
        end
        rd = 1'b0;
        tick;
    endtask

    task automatic test_order;
        logic [7:0] got, exp;
        int         low;
        push(8'h11, $urandom_range(1, 4));
        push(8'h22, $urandom_range(1, 4));
        push(8'h33, $urandom_range(1, 4));
        for (int i = 0; i < 10 && nmi !== 1'b1; i++) tick;
        vec++; if (nmi !== 1'b1) begin errs++; $display("FAIL order_snmi: got %b want 1", nmi); end
        for (int k = 0; k < 3; k++) begin
            if (q.size() > 0) begin
                exp = q[0];
                read(3, got);
                vec++; if (got !== exp) begin errs++; $display("FAIL order_data[%0d]: got %h want %h", k, got, exp); end
                if (q.size() > 0) begin
                    low = 0;
                    while (nmi === 1'b0 && low < 100) begin low++; tick; end
                    vec++; if (low != GAP) begin errs++; $display("FAIL order_gap[%0d]: got %0d want %0d", k, low, GAP); end
                end
            end
        end
        repeat (40) tick;
    endtask

    task automatic test_gap_push;
        logic [7:0] got, b0, b1;
        int         low;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        push(b0, 2);
        for (int i = 0; i < 60 && nmi !== 1'b1; i++) tick;
        read(2, got);
        vec++; if (got !== b0) begin errs++; $display("FAIL gap_first: got %h want %h", got, b0); end
        low = 0;
        while (nmi === 1'b0 && low < 100) begin
            low++;
            if (low == 5) begin no = b1; rq = 1'b1; model_push(b1); end
            if (low == 8) rq = 1'b0;
            tick;
        end
        rq = 1'b0;
        vec++; if (low != GAP) begin errs++; $display("FAIL gap_push_len: got %0d want %0d", low, GAP); end
        read(2, got);
        vec++; if (got !== b1) begin errs++; $display("FAIL gap_second: got %h want %h", got, b1); end
    endtask

    task automatic test_overflow;
        logic [7:0] got, exp;
        do_reset;
        for (int i = 0; i < 5; i++) push(8'($urandom), $urandom_range(1, 3));
        vec++; if (level !== LW'(q.size())) begin errs++; $display("FAIL ovf_level: got %0d want %0d", level, q.size()); end
        vec++; if (ovf_o !== ovf) begin errs++; $display("FAIL ovf_flag: got %b want %b", ovf_o, ovf); end
        while (q.size() > 0) begin
            exp = q[0];
            read($urandom_range(1, 4), got);
            vec++; if (got !== exp) begin errs++; $display("FAIL ovf_drain: got %h want %h", got, exp); end
        end
        vec++; if (level !== '0) begin errs++; $display("FAIL ovf_empty: got %0d want 0", level); end
    endtask

    task automatic test_simul;
        logic [7:0] got, exp, nb;
        do_reset;
        for (int i = 0; i < CAP; i++) push(8'($urandom), 1);
        vec++; if (level !== LW'(CAP)) begin errs++; $display("FAIL simul_full: got %0d want %0d", level, CAP); end
        nb = 8'($urandom);
        ad = 16'hE123; rd = 1'b1;
        repeat (3) tick;
        rd = 1'b0; no = nb; rq = 1'b1;
        model_pop();
        model_push(nb);
        tick;
        vec++; if (level !== LW'(q.size())) begin errs++; $display("FAIL simul_level: got %0d want %0d", level, q.size()); end
        vec++; if (ovf_o !== 1'b0) begin errs++; $display("FAIL simul_ovf: got %b want 0", ovf_o); end
        rq = 1'b0;
        tick;
        while (q.size() > 0) begin
            exp = q[0];
            read(2, got);
            vec++; if (got !== exp) begin errs++; $display("FAIL simul_drain: got %h want %h", got, exp); end
        end
        vec++; if (exp !== nb) begin errs++; $display("FAIL simul_last: got %h want %h", exp, nb); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] got;
        do_reset;
        for (int i = 0; i < 3; i++) push(8'($urandom_range(1, 255)), 1);
        vec++; if (level !== LW'(q.size())) begin errs++; $display("FAIL mid_level: got %0d want %0d", level, q.size()); end
        for (int i = 0; i < 10 && nmi !== 1'b1; i++) tick;
        vec++; if (nmi !== 1'b1) begin errs++; $display("FAIL mid_snmi: got %b want 1", nmi); end
        rst = 1'b1;
        tick;
        vec++; if (dout !== 8'h00) begin errs++; $display("FAIL mid_snddo: got %h want 00", dout); end
        vec++; if (nmi !== 1'b0) begin errs++; $display("FAIL mid_snmi_rst: got %b want 0", nmi); end
        vec++; if (level !== '0) begin errs++; $display("FAIL mid_level_rst: got %0d want 0", level); end
        vec++; if (ovf_o !== 1'b0) begin errs++; $display("FAIL mid_ovf_rst: got %b want 0", ovf_o); end
        rst = 1'b0;
        q.delete();
        ovf = 1'b0;
        tick;
        read(4, got);
        vec++; if (got !== 8'h00) begin errs++; $display("FAIL mid_read: got %h want 00", got); end
        vec++; if (level !== '0) begin errs++; $display("FAIL mid_read_level: got %0d want 0", level); end
    endtask

    task automatic test_random;
        logic [7:0] got, exp;
        bit         have;
        do_reset;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                push(8'($urandom), $urandom_range(1, 3));
            end else begin
                have = q.size() > 0;
                exp  = have ? q[0] : 8'h00;
                read($urandom_range(1, 4), got);
                if (have) begin
                    vec++; if (got !== exp) begin errs++; $display("FAIL rand_data[%0d]: got %h want %h", i, got, exp); end
                end
            end
            vec++; if (level !== LW'(q.size())) begin errs++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, level, q.size()); end
            vec++; if (ovf_o !== ovf) begin errs++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, ovf_o, ovf); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_sndcs;
        test_order;
        test_gap_push;
        test_overflow;
        test_simul;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
